// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: pipelined Ladner-Fischer add/sub with valid/ready; define ADDER_SATURATE_EN to clamp overflowing sums
module pipelined_prefix_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LV = $clog2(WIDTH);
  function automatic int lo(input int s);
    return s * (LV / STAGES) + (s < LV % STAGES ? s : LV % STAGES);
  endfunction
  logic [WIDTH-1:0] g_q [STAGES];
  logic [WIDTH-1:0] g_d [STAGES];
  logic [WIDTH-1:0] p_q [STAGES];
  logic [WIDTH-1:0] p_d [STAGES];
  logic [WIDTH-1:0] pp_q [STAGES];
  logic [WIDTH-1:0] pp_d [STAGES];
  logic [STAGES-1:0] c0_q, c0_d, v_q, v_d, adv;
  logic [WIDTH-1:0] sum_q, sum_d, bx, tg, tp, tpp, raw;
  logic cout_q, cout_d, ovf_q, ovf_d, tc, nxt, pv, co_n, ov_n;
  always_comb begin
    adv = '0;
    v_d = v_q;
    nxt = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s] = ~v_q[s] | nxt;
      nxt = adv[s];
    end
    pv = in_valid;
    for (int s = 0; s < STAGES; s++) begin
      v_d[s] = adv[s] ? pv : v_q[s];
      pv = v_q[s];
    end
  end
  always_comb begin
    g_d = g_q;
    p_d = p_q;
    pp_d = pp_q;
    c0_d = c0_q;
    bx = sub ? ~b : b;
    tc = sub ? ~cin : cin;
    tpp = a ^ bx;
    tp = tpp;
    tg = a & bx;
    tg[0] = tg[0] | (tp[0] & tc);
    tp[0] = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      for (int l = 0; l < LV; l++)
        if (l >= lo(s) && l < lo(s + 1))
          for (int i = 0; i < WIDTH; i++)
            if (((i >> l) & 1) == 1) begin
              tg[i] = tg[i] | (tp[i] & tg[((i >> l) << l) - 1]);
              tp[i] = tp[i] & tp[((i >> l) << l) - 1];
            end
      if (s < STAGES - 1) begin
        g_d[s] = adv[s] ? tg : g_q[s];
        p_d[s] = adv[s] ? tp : p_q[s];
        pp_d[s] = adv[s] ? tpp : pp_q[s];
        c0_d[s] = adv[s] ? tc : c0_q[s];
        tg = g_q[s];
        tp = p_q[s];
        tpp = pp_q[s];
        tc = c0_q[s];
      end
    end
    // tg[i] now holds carry into bit i+1; tc is the carry into bit 0
    raw = tpp ^ {tg[WIDTH-2:0], tc};
    co_n = tg[WIDTH-1];
    ov_n = tg[WIDTH-1] ^ tg[WIDTH-2];
`ifdef ADDER_SATURATE_EN
    raw = ov_n ? {co_n, {(WIDTH-1){~co_n}}} : raw;
`else
`endif
    sum_d = adv[STAGES-1] ? raw : sum_q;
    cout_d = adv[STAGES-1] ? co_n : cout_q;
    ovf_d = adv[STAGES-1] ? ov_n : ovf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      c0_q <= '0;
      g_q <= '{default: '0};
      p_q <= '{default: '0};
      pp_q <= '{default: '0};
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      v_q <= v_d;
      c0_q <= c0_d;
      g_q <= g_d;
      p_q <= p_d;
      pp_q <= pp_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  assign in_ready = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder: arithmetic reference model plus directed latency, backpressure and reset checks
module tb_pipelined_prefix_adder;
  localparam int W = 16;
`ifdef ADDER_SATURATE_EN
  localparam logic [17:0] E_OVF_ADD = 18'h27FFF;
  localparam logic [17:0] E_OVF_SUB = 18'h38000;
`else
  localparam logic [17:0] E_OVF_ADD = 18'h28000;
  localparam logic [17:0] E_OVF_SUB = 18'h37FFF;
`endif
  logic clk = 0, rst = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
  logic [W-1:0] a = 0, b = 0, sum;
  logic in_ready, out_valid, cout, ovf;
  int checks = 0, errors = 0;
  logic [17:0] q[$];
  bit done;

  pipelined_prefix_adder #(.WIDTH(W), .STAGES(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] x, y, input logic ci, s);
    longint sx, sy, tr, ux, uy;
    logic [15:0] r;
    logic co, ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    tr = s ? sx - sy - longint'(ci) : sx + sy + longint'(ci);
    ov = tr > 32767 || tr < -32768;
    r = 16'(s ? ux - uy - longint'(ci) : ux + uy + longint'(ci));
    co = s ? (ux >= uy + longint'(ci)) : (ux + uy + longint'(ci) > 65535);
`ifdef ADDER_SATURATE_EN
    if (ov) r = tr > 0 ? 16'h7FFF : 16'h8000;
`endif
    return {ov, co, r};
  endfunction

  always @(negedge clk)
    if (!rst) begin
      if (out_ready) chk("in_ready_with_out_ready", in_ready, 1);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("stream_result", {ovf, cout, sum}, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end

  task automatic put(input logic [15:0] x, y, input logic ci, s);
    bit ok;
    int n = 0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("put_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic lat(input string n, input logic [15:0] x, y, input logic ci, s, input logic [17:0] e);
    @(posedge clk) #1;
    a = x; b = y; cin = ci; sub = s; in_valid = 1;
    @(posedge clk) #1 in_valid = 0;
    @(negedge clk) chk({n, "_lat1"}, out_valid, 0);
    @(negedge clk) chk({n, "_lat2"}, out_valid, 0);
    @(negedge clk) chk({n, "_valid"}, out_valid, 1);
    chk(n, {ovf, cout, sum}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int n;
    int exp3[3] = '{4, 6, 8};
    #2 rst = 1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("model_add_carry", model(16'hFFFF, 16'h0001, 0, 0), 18'h10000);
    chk("model_add_ovf", model(16'h7FFF, 16'h0001, 0, 0), E_OVF_ADD);
    chk("model_sub_borrow", model(16'h0005, 16'h0007, 0, 1), 18'h0FFFE);
    chk("model_sub_ovf", model(16'h8000, 16'h0001, 0, 1), E_OVF_SUB);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk) chk("in_ready_after_reset", in_ready, 1);
    lat("add_carry", 16'hFFFF, 16'h0001, 0, 0, 18'h10000);
    lat("add_ovf", 16'h7FFF, 16'h0001, 0, 0, E_OVF_ADD);
    lat("sub_borrow", 16'h0005, 16'h0007, 0, 1, 18'h0FFFE);
    lat("sub_ovf", 16'h8000, 16'h0001, 0, 1, E_OVF_SUB);
    lat("add_cin", 16'h1234, 16'h1111, 1, 0, 18'h02346);
    lat("sub_cin", 16'h0010, 16'h0001, 1, 1, 18'h1000E);
    @(posedge clk) #1 out_ready = 0;
    put(1, 1, 0, 0);
    put(2, 2, 0, 0);
    put(3, 3, 0, 0);
    a = 4; b = 4; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_hold_sum", sum, 2);
      chk("bp_hold_valid", out_valid, 1);
    end
    @(posedge clk) #1 out_ready = 1;
    @(negedge clk);
    chk("bp_release_sum", sum, 2);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk) #1 in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_sum", sum, exp3[k]);
    end
    @(posedge clk) #1;
    done = 0;
    fork
      begin
        for (int k = 0; k < 100; k++)
          put(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stream_drained", q.size(), 0);
    @(posedge clk) #1 out_ready = 0;
    put(16'h0011, 16'h0022, 0, 0);
    put(16'h0033, 16'h0044, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_reset_valid", out_valid, 1);
    rst = 1;
    q.delete();
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_sum", sum, 0);
    chk("midreset_cout", cout, 0);
    chk("midreset_ovf", ovf, 0);
    @(posedge clk) #1 rst = 0;
    out_ready = 1;
    @(negedge clk) chk("post_reset_in_ready", in_ready, 1);
    repeat (10) @(negedge clk) chk("no_stale_beat", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
